// File: rtl/audio_play_sequencer.sv
// ============================================================================
//  Module      : audio_play_sequencer
//  Description : Audioport playback sequencer. Decodes one-hot commands,
//                runs the idle/play state machine, divides clk down to the
//                sample tick, pops stereo samples from the audio FIFOs and
//                drives the status flags and refill interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_play_sequencer #(
   parameter int FIFO_SIZE  = 56,
   parameter int DATA_WIDTH = 24,
   parameter int IRQ_LEVEL  = 28
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cmd_valid_in,
   input  logic [31:0]                    cmd_in,
   input  logic [31:0]                    clkdiv_in,
   input  logic [$clog2(FIFO_SIZE+1)-1:0] left_level_in,
   input  logic [$clog2(FIFO_SIZE+1)-1:0] right_level_in,
   input  logic [DATA_WIDTH-1:0]          left_data_in,
   input  logic [DATA_WIDTH-1:0]          right_data_in,
   output logic                           fifo_pop_out,
   output logic                           fifo_clr_out,
   output logic                           cfg_out,
   output logic                           level_out,
   output logic                           tick_out,
   output logic [DATA_WIDTH-1:0]          audio0_out,
   output logic [DATA_WIDTH-1:0]          audio1_out,
   output logic                           valid_out,
   output logic                           play_out,
   output logic                           nodata_out,
   output logic                           irq_out
);

   localparam int LW = $clog2(FIFO_SIZE+1);

   // Command encodings (one bit each in cmd_in[5:0])
   localparam logic [5:0] c_cmd_clr    = 6'b000001;
   localparam logic [5:0] c_cmd_cfg    = 6'b000010;
   localparam logic [5:0] c_cmd_start  = 6'b000100;
   localparam logic [5:0] c_cmd_stop   = 6'b001000;
   localparam logic [5:0] c_cmd_level  = 6'b010000;
   localparam logic [5:0] c_cmd_irqack = 6'b100000;

   localparam logic [LW-1:0] c_irq_level = LW'(IRQ_LEVEL);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } state_t;

   state_t                r_state;
   logic [31:0]           r_cnt;
   logic                  r_pop;
   logic                  r_clr;
   logic                  r_cfg;
   logic                  r_level;
   logic                  r_tick;
   logic                  r_valid;
   logic                  r_play;
   logic                  r_nodata;
   logic                  r_irq;
   logic [DATA_WIDTH-1:0] r_audio0;
   logic [DATA_WIDTH-1:0] r_audio1;

   logic [5:0]  w_low;
   logic        w_acc;
   logic        w_cmd_clr;
   logic        w_cmd_cfg;
   logic        w_cmd_start;
   logic        w_cmd_stop;
   logic        w_cmd_level;
   logic        w_cmd_irqack;
   logic [31:0] w_eff_div;
   logic        w_have_data;
   logic        w_irq_cond;

   // Command legality: strobe, upper bits clear, exactly one low bit set
   always_comb begin
      w_low        = cmd_in[5:0];
      w_acc        = cmd_valid_in && (cmd_in[31:6] == 26'd0) && (w_low != 6'd0) &&
                     ((w_low & (w_low - 6'd1)) == 6'd0);
      w_cmd_clr    = w_acc && (w_low == c_cmd_clr);
      w_cmd_cfg    = w_acc && (w_low == c_cmd_cfg);
      w_cmd_start  = w_acc && (w_low == c_cmd_start);
      w_cmd_stop   = w_acc && (w_low == c_cmd_stop);
      w_cmd_level  = w_acc && (w_low == c_cmd_level);
      w_cmd_irqack = w_acc && (w_low == c_cmd_irqack);
      // Divider below 2 would make the tick continuous; clamp it
      w_eff_div    = (clkdiv_in < 32'd2) ? 32'd2 : clkdiv_in;
      w_have_data  = (left_level_in != '0) && (right_level_in != '0);
      w_irq_cond   = (left_level_in <= c_irq_level) || !w_have_data;
   end

   // Play/idle state machine, divider, sample fetch and status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 32'd0;
         r_pop    <= 1'b0;
         r_clr    <= 1'b0;
         r_cfg    <= 1'b0;
         r_level  <= 1'b0;
         r_tick   <= 1'b0;
         r_valid  <= 1'b0;
         r_play   <= 1'b0;
         r_nodata <= 1'b0;
         r_irq    <= 1'b0;
         r_audio0 <= '0;
         r_audio1 <= '0;
      end else begin
         r_pop   <= 1'b0;
         r_clr   <= 1'b0;
         r_cfg   <= 1'b0;
         r_tick  <= 1'b0;
         r_valid <= 1'b0;
         r_level <= w_cmd_level;
         // Acknowledge first so that a coincident set condition below wins
         if (w_cmd_irqack) r_irq <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_cmd_start) begin
                  r_state <= ST_PLAY;
                  r_play  <= 1'b1;
                  r_cnt   <= w_eff_div - 32'd1;
               end
               if (w_cmd_clr) begin
                  r_clr    <= 1'b1;
                  r_nodata <= 1'b0;
               end
               if (w_cmd_cfg) r_cfg <= 1'b1;
            end
            ST_PLAY: begin
               if (w_cmd_stop) begin
                  // Stop suppresses any tick and discards a pending sample
                  r_state  <= ST_IDLE;
                  r_play   <= 1'b0;
                  r_cnt    <= 32'd0;
                  r_irq    <= 1'b0;
                  r_audio0 <= '0;
                  r_audio1 <= '0;
               end else begin
                  // FIFO head is still valid on the edge that performs the pop
                  if (r_tick) begin
                     r_valid  <= 1'b1;
                     r_audio0 <= r_pop ? left_data_in  : '0;
                     r_audio1 <= r_pop ? right_data_in : '0;
                  end
                  if (r_cnt == 32'd0) begin
                     r_tick <= 1'b1;
                     r_cnt  <= w_eff_div - 32'd1;
                     if (w_have_data) r_pop    <= 1'b1;
                     else             r_nodata <= 1'b1;
                     if (w_irq_cond)  r_irq    <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt - 32'd1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign fifo_pop_out = r_pop;
   assign fifo_clr_out = r_clr;
   assign cfg_out      = r_cfg;
   assign level_out    = r_level;
   assign tick_out     = r_tick;
   assign audio0_out   = r_audio0;
   assign audio1_out   = r_audio1;
   assign valid_out    = r_valid;
   assign play_out     = r_play;
   assign nodata_out   = r_nodata;
   assign irq_out      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_audio_play_sequencer.sv
// ============================================================================
//  Module      : tb_audio_play_sequencer
//  Description : Directed self-checking bench for audio_play_sequencer with
//                a sample scoreboard and a behavioural expectation model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_play_sequencer;

   localparam logic [31:0] c_nop    = 32'h00;
   localparam logic [31:0] c_clr    = 32'h01;
   localparam logic [31:0] c_cfg    = 32'h02;
   localparam logic [31:0] c_start  = 32'h04;
   localparam logic [31:0] c_stop   = 32'h08;
   localparam logic [31:0] c_level  = 32'h10;
   localparam logic [31:0] c_irqack = 32'h20;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid_in;
   logic [31:0] cmd_in;
   logic [31:0] clkdiv_in;
   logic [5:0]  left_level_in, right_level_in;
   logic [23:0] left_data_in, right_data_in;
   logic        fifo_pop_out, fifo_clr_out, cfg_out, level_out, tick_out;
   logic [23:0] audio0_out, audio1_out;
   logic        valid_out, play_out, nodata_out, irq_out;

   int vectors = 0;
   int miscompares = 0;

   // Expectation model state
   bit          m_play, m_irq, m_nodata, m_tick_prev;
   int          m_tcnt;
   logic [47:0] sb[$];

   audio_play_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid_in(cmd_valid_in), .cmd_in(cmd_in), .clkdiv_in(clkdiv_in),
      .left_level_in(left_level_in), .right_level_in(right_level_in),
      .left_data_in(left_data_in), .right_data_in(right_data_in),
      .fifo_pop_out(fifo_pop_out), .fifo_clr_out(fifo_clr_out),
      .cfg_out(cfg_out), .level_out(level_out), .tick_out(tick_out),
      .audio0_out(audio0_out), .audio1_out(audio1_out),
      .valid_out(valid_out), .play_out(play_out),
      .nodata_out(nodata_out), .irq_out(irq_out)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int eff(input logic [31:0] d);
      return (d < 32'd2) ? 2 : int'(d);
   endfunction

   // One clock cycle: predict, advance to the next negedge, compare
   task automatic step();
      logic [5:0] c;
      logic acc, have, was_play, stop_acc;
      logic e_tick, e_pop, e_valid, e_clr, e_cfg, e_lvl;
      logic [47:0] exp_pair;
      c        = cmd_in[5:0];
      acc      = cmd_valid_in && (cmd_in[31:6] == 26'd0) && ($countones(c) == 1);
      have     = (left_level_in != 0) && (right_level_in != 0);
      was_play = m_play;
      e_tick = 0; e_pop = 0; e_valid = 0; stop_acc = 0;
      e_clr  = acc && (cmd_in == c_clr) && !was_play;
      e_cfg  = acc && (cmd_in == c_cfg) && !was_play;
      e_lvl  = acc && (cmd_in == c_level);
      if (acc && cmd_in == c_irqack) m_irq = 0;
      if (was_play) begin
         if (acc && cmd_in == c_stop) begin
            stop_acc = 1; m_play = 0; m_irq = 0; sb.delete();
         end else begin
            e_valid = m_tick_prev;
            m_tcnt--;
            if (m_tcnt == 0) begin
               e_tick = 1;
               m_tcnt = eff(clkdiv_in);
               e_pop  = have;
               if (!have) m_nodata = 1;
               if (left_level_in <= 6'd28 || !have) m_irq = 1;
            end
         end
      end else begin
         if (acc && cmd_in == c_start) begin
            m_play = 1;
            m_tcnt = eff(clkdiv_in);
         end
         if (e_clr) m_nodata = 0;
      end
      m_tick_prev = e_tick;

      @(negedge clk);
      chk("tick",   tick_out,     e_tick);
      chk("pop",    fifo_pop_out, e_pop);
      chk("valid",  valid_out,    e_valid);
      chk("play",   play_out,     m_play);
      chk("irq",    irq_out,      m_irq);
      chk("nodata", nodata_out,   m_nodata);
      chk("clr",    fifo_clr_out, e_clr);
      chk("cfg",    cfg_out,      e_cfg);
      chk("level",  level_out,    e_lvl);
      if (stop_acc) begin
         chk("stop_audio", {audio0_out, audio1_out}, 48'd0);
      end
      if (e_valid) begin
         if (sb.size() == 0) begin
            chk("sb_empty", 1'b1, 1'b0);
         end else begin
            exp_pair = sb.pop_front();
            chk("audio", {audio0_out, audio1_out}, exp_pair);
         end
         left_data_in  = 24'($urandom);
         right_data_in = 24'($urandom);
      end
      if (e_tick) sb.push_back(have ? {left_data_in, right_data_in} : 48'd0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic cmd(input logic [31:0] c);
      cmd_valid_in = 1'b1;
      cmd_in       = c;
      step();
      cmd_valid_in = 1'b0;
      cmd_in       = 32'd0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pulses"}, {fifo_pop_out, fifo_clr_out, cfg_out, level_out, tick_out, valid_out}, 6'd0);
      chk({tag, "_flags"},  {play_out, nodata_out, irq_out}, 3'd0);
      chk({tag, "_audio"},  {audio0_out, audio1_out}, 48'd0);
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid_in = 1'b0; cmd_in = 32'd0; clkdiv_in = 32'd5;
      left_level_in = 6'd40; right_level_in = 6'd40;
      left_data_in = 24'($urandom); right_data_in = 24'($urandom);
      m_play = 0; m_irq = 0; m_nodata = 0; m_tick_prev = 0; m_tcnt = 0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      run(2);

      // Normal playback, period 5, no interrupt at level 40
      cmd(c_start);
      run(16);

      // Low left level raises irq; ack coincident with a set keeps it
      left_level_in = 6'd28;
      run(6);
      for (int i = 0; i < 20 && m_tcnt != 1; i++) step();
      cmd(c_irqack);
      chk("irq_set_wins", irq_out, 1'b1);
      cmd(c_irqack);
      left_level_in = 6'd40;
      run(6);

      // Empty right FIFO: silence, nodata, irq
      right_level_in = 6'd0;
      run(6);
      right_level_in = 6'd40;

      // CFG/CLR ignored while playing, LEVEL honoured
      cmd(c_cfg);
      cmd(c_clr);
      cmd(c_level);
      run(2);

      // Illegal and NOP commands
      cmd(32'h0000_0006);
      cmd(c_nop);
      cmd(32'h0000_0040);
      cmd(32'h8000_0004);
      run(2);

      // Divider clamp
      clkdiv_in = 32'd0;
      run(9);
      clkdiv_in = 32'd5;

      // Stop, then idle commands
      cmd(c_stop);
      run(3);
      cmd(c_clr);
      cmd(c_cfg);
      cmd(c_level);
      cmd(c_stop);
      cmd(c_irqack);
      run(3);

      // Reset two cycles before an expected tick
      cmd(c_start);
      for (int i = 0; i < 20 && m_tcnt != 2; i++) step();
      rst = 1'b1;
      #1;
      chk_all_zero("midreset");
      repeat (3) @(negedge clk);
      chk_all_zero("heldreset");
      rst = 1'b0;
      m_play = 0; m_irq = 0; m_nodata = 0; m_tick_prev = 0; sb.delete();
      run(12);

      // Playback resumes after a new start
      cmd(c_start);
      run(12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/audio_play_sequencer.md
Name: audio_play_sequencer

Overview:
- Sequences audioport playback: decodes one-hot CMD_REG commands, runs the play/idle state machine and generates the sample-rate tick from the programmed clock divider.
- On each tick it pops one stereo sample from the left/right audio FIFOs and presents it to dsp_unit.
- It drives the STATUS_REG flags (PLAY, NODATA) and the refill interrupt.
- Sits between the APB register file/FIFOs and dsp_unit; runs entirely in the clk domain.

Parameters:
- FIFO_SIZE, 56, depth of each audio FIFO (AUDIO_FIFO_SIZE).
- DATA_WIDTH, 24, audio sample width.
- IRQ_LEVEL, 28, FIFO fill level at or below which a refill interrupt is raised (default FIFO_SIZE/2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- cmd_valid_in  in  1  one-cycle strobe: CMD_REG written.
- cmd_in  in  32  command word (CMD_NOP..CMD_IRQACK encodings).
- clkdiv_in  in  32  clk cycles per sample (e.g. CLK_DIV_48000).
- left_level_in  in  $clog2(FIFO_SIZE+1)  left FIFO fill count.
- right_level_in  in  $clog2(FIFO_SIZE+1)  right FIFO fill count.
- left_data_in  in  DATA_WIDTH  left FIFO head.
- right_data_in  in  DATA_WIDTH  right FIFO head.
- fifo_pop_out  out  1  pop both FIFOs (one-cycle pulse).
- fifo_clr_out  out  1  flush both FIFOs (one-cycle pulse).
- cfg_out  out  1  latch CFG/DSP registers into dsp_unit (pulse).
- level_out  out  1  latch LEVEL_REG into dsp_unit (pulse).
- tick_out  out  1  sample tick (pulse).
- audio0_out  out  DATA_WIDTH  left sample to dsp_unit.
- audio1_out  out  DATA_WIDTH  right sample to dsp_unit.
- valid_out  out  1  audio0/1_out valid (pulse).
- play_out  out  1  STATUS_PLAY.
- nodata_out  out  1  STATUS_NODATA (sticky).
- irq_out  out  1  refill interrupt (level).

Behaviour:
- Reset: state IDLE. All outputs 0. Divider counter 0.
- Command acceptance:
  - A command is accepted only when cmd_valid_in=1 and cmd_in has exactly one bit set within [5:0] and bits [31:6]=0.
  - Anything else, including CMD_NOP, is ignored.
- IDLE state:
  - CMD_START: go to PLAY next cycle; play_out=1; counter loaded with eff_div-1.
  - CMD_CLR: fifo_clr_out pulse next cycle; nodata_out cleared.
  - CMD_CFG: cfg_out pulse next cycle.
  - CMD_STOP: no effect.
- PLAY state:
  - CMD_CLR and CMD_CFG are ignored (cfg changes forbidden while playing).
  - CMD_STOP: go to IDLE next cycle; play_out=0; counter cleared; irq_out cleared; audio outputs forced to 0; no tick is produced in the cycle STOP is accepted.
  - CMD_START: no effect.
- Commands valid in any state:
  - CMD_LEVEL: level_out pulse next cycle.
  - CMD_IRQACK: clears irq_out next cycle.
- Divider:
  - eff_div = max(clkdiv_in, 2). clkdiv_in is sampled on each reload.
  - In PLAY the counter decrements each cycle. When it reaches 0: tick_out=1 for that cycle and the counter reloads eff_div-1.
  - First tick comes eff_div cycles after START is accepted. Tick period is exactly eff_div cycles.
- Sample fetch at a tick:
  - If left_level_in>0 and right_level_in>0: fifo_pop_out=1 in the same cycle as tick_out. Next cycle: audio0_out=left_data_in, audio1_out=right_data_in (registered at the tick edge), valid_out=1.
  - If either FIFO is empty: no pop; next cycle audio0/1_out=0 and valid_out=1 (silence is still played); nodata_out set (sticky until CMD_CLR in IDLE).
  - Latency from tick to valid: 1 cycle.
  - audio0/1_out hold their value between valid pulses.
- Interrupt:
  - At a tick in PLAY, irq_out is set if the pre-pop left_level_in <= IRQ_LEVEL or either FIFO is empty.
  - irq_out stays set until CMD_IRQACK or STOP.
  - If IRQACK is accepted in the same cycle as a set condition, set wins.
- Reset asserted mid-play: immediate return to reset values; no pop or tick is generated.

Test Plan:
- Reset, then cmd CMD_START with clkdiv_in=5 and both FIFOs level 40 -> play_out=1; tick_out every 5 cycles (first 5 cycles after accept); fifo_pop_out coincident with each tick; valid_out 1 cycle later carrying the FIFO head values; irq_out stays 0.
- PLAY with left level 28, right level 40 at a tick -> irq_out=1; CMD_IRQACK -> irq_out=0 next cycle; IRQACK coincident with a set condition -> irq_out stays 1.
- PLAY with right FIFO level 0 at a tick -> no pop; audio0/1_out=0 with valid_out=1; nodata_out=1. CMD_STOP then CMD_CLR -> fifo_clr_out pulse; nodata_out=0.
- CMD_CFG and CMD_CLR issued in PLAY -> no cfg_out or fifo_clr_out. Same commands in IDLE -> single pulses. CMD_LEVEL in PLAY -> level_out pulse.
- Illegal cmd 32'h00000006 and CMD_NOP -> no state change, no pulses. clkdiv_in=0 in PLAY -> tick every 2 cycles.
- rst asserted 2 cycles before an expected tick -> all outputs 0 immediately; no tick or pop after release until a new START is accepted.
